// File: rtl/ast_dmx.sv
// Avalon-ST 1-to-N packet demultiplexer: a whole packet follows the direction
// sampled on its start beat, and each direction has a one-deep output register.
module ast_dmx #(
  parameter int DATA_WIDTH    = 64,
  parameter int EMPTY_WIDTH   = $clog2(DATA_WIDTH/8),
  parameter int CHANNEL_WIDTH = 8,
  parameter int TX_DIR        = 4,
  parameter int DIR_SEL_WIDTH = (TX_DIR == 1) ? 1 : $clog2(TX_DIR)
) (
  input  logic                     clk_i,
  input  logic                     srst_i,
  input  logic [DIR_SEL_WIDTH-1:0] dir_i,

  input  logic [DATA_WIDTH-1:0]    ast_data_i,
  input  logic                     ast_startofpacket_i,
  input  logic                     ast_endofpacket_i,
  input  logic                     ast_valid_i,
  input  logic [EMPTY_WIDTH-1:0]   ast_empty_i,
  input  logic [CHANNEL_WIDTH-1:0] ast_channel_i,
  output logic                     ast_ready_o,

  output logic [DATA_WIDTH-1:0]    ast_data_o          [TX_DIR-1:0],
  output logic [TX_DIR-1:0]        ast_startofpacket_o,
  output logic [TX_DIR-1:0]        ast_endofpacket_o,
  output logic [TX_DIR-1:0]        ast_valid_o,
  output logic [EMPTY_WIDTH-1:0]   ast_empty_o         [TX_DIR-1:0],
  output logic [CHANNEL_WIDTH-1:0] ast_channel_o       [TX_DIR-1:0],
  input  logic [TX_DIR-1:0]        ast_ready_i
);

  typedef enum logic {
    ST_IDLE,
    ST_IN_PKT
  } state_e;

  state_e                   state_q, state_d;
  logic [DIR_SEL_WIDTH-1:0] sel_q, sel_d;
  logic [DIR_SEL_WIDTH-1:0] eff_dir;
  logic [31:0]              eff_dir_ext;
  logic                     dir_ok;
  logic                     accept;
  logic [TX_DIR-1:0]        load;

  logic [DATA_WIDTH-1:0]    data_q  [TX_DIR-1:0];
  logic [DATA_WIDTH-1:0]    data_d  [TX_DIR-1:0];
  logic [EMPTY_WIDTH-1:0]   empty_q [TX_DIR-1:0];
  logic [EMPTY_WIDTH-1:0]   empty_d [TX_DIR-1:0];
  logic [CHANNEL_WIDTH-1:0] chan_q  [TX_DIR-1:0];
  logic [CHANNEL_WIDTH-1:0] chan_d  [TX_DIR-1:0];
  logic [TX_DIR-1:0]        sop_q, sop_d;
  logic [TX_DIR-1:0]        eop_q, eop_d;
  logic [TX_DIR-1:0]        valid_q, valid_d;

  // Mid-packet the locked selection wins; between packets dir_i routes directly.
  always_comb begin
    eff_dir     = (state_q == ST_IN_PKT) ? sel_q : dir_i;
    eff_dir_ext = 32'(eff_dir);
    dir_ok      = (eff_dir_ext < 32'(TX_DIR));
  end

  // An out-of-range direction swallows beats so the source never stalls.
  always_comb begin
    ast_ready_o = 1'b1;
    if (dir_ok) begin
      ast_ready_o = !valid_q[eff_dir] || ast_ready_i[eff_dir];
    end
  end

  assign accept = ast_valid_i && ast_ready_o;

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    if (accept) begin
      if (ast_startofpacket_i) begin
        if (!ast_endofpacket_i) begin
          state_d = ST_IN_PKT;
          sel_d   = dir_i;
        end else begin
          state_d = ST_IDLE;
        end
      end else if (ast_endofpacket_i) begin
        state_d = ST_IDLE;
      end
    end
  end

  always_comb begin
    load    = '0;
    valid_d = valid_q;
    sop_d   = sop_q;
    eop_d   = eop_q;
    data_d  = data_q;
    empty_d = empty_q;
    chan_d  = chan_q;
    for (int d = 0; d < TX_DIR; d++) begin
      load[d] = accept && dir_ok && (eff_dir_ext == 32'(d));
      if (load[d]) begin
        valid_d[d] = 1'b1;
        sop_d[d]   = ast_startofpacket_i;
        eop_d[d]   = ast_endofpacket_i;
        data_d[d]  = ast_data_i;
        empty_d[d] = ast_empty_i;
        chan_d[d]  = ast_channel_i;
      end else if (ast_ready_i[d]) begin
        valid_d[d] = 1'b0;
      end
    end
  end

  // NOTE: all state uses non-blocking assignments so every flop samples the
  // pre-edge values of the others; blocking here would create ordering races.
  always_ff @(posedge clk_i or negedge srst_i) begin
    if (!srst_i) begin
      state_q <= ST_IDLE;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
    end
  end

  // NOTE: the payload registers are reset too, because the outputs must read
  // zero during reset; normally data-only storage would be left unreset.
  always_ff @(posedge clk_i or negedge srst_i) begin
    if (!srst_i) begin
      valid_q <= '0;
      sop_q   <= '0;
      eop_q   <= '0;
      for (int d = 0; d < TX_DIR; d++) begin
        data_q[d]  <= '0;
        empty_q[d] <= '0;
        chan_q[d]  <= '0;
      end
    end else begin
      valid_q <= valid_d;
      sop_q   <= sop_d;
      eop_q   <= eop_d;
      data_q  <= data_d;
      empty_q <= empty_d;
      chan_q  <= chan_d;
    end
  end

  assign ast_valid_o         = valid_q;
  assign ast_startofpacket_o = sop_q;
  assign ast_endofpacket_o   = eop_q;
  assign ast_data_o          = data_q;
  assign ast_empty_o         = empty_q;
  assign ast_channel_o       = chan_q;

endmodule

// File: tb/tb_ast_dmx.sv
// Bench for ast_dmx: directed packet scenarios, then a randomized run checked
// against one in-order scoreboard queue per direction.
module tb_ast_dmx;

  localparam int DW = 64;
  localparam int EW = 3;
  localparam int CW = 8;
  localparam int TD = 4;
  localparam int SW = 2;
  localparam int NPKT = 150;

  logic          clk_i = 1'b0;
  logic          srst_i;
  logic [SW-1:0] dir_i;
  logic [DW-1:0] ast_data_i;
  logic          ast_startofpacket_i;
  logic          ast_endofpacket_i;
  logic          ast_valid_i;
  logic [EW-1:0] ast_empty_i;
  logic [CW-1:0] ast_channel_i;
  logic          ast_ready_o;
  logic [DW-1:0] ast_data_o    [TD-1:0];
  logic [TD-1:0] ast_startofpacket_o;
  logic [TD-1:0] ast_endofpacket_o;
  logic [TD-1:0] ast_valid_o;
  logic [EW-1:0] ast_empty_o   [TD-1:0];
  logic [CW-1:0] ast_channel_o [TD-1:0];
  logic [TD-1:0] ast_ready_i;

  always #5 clk_i = ~clk_i;

  ast_dmx #(
    .DATA_WIDTH   (DW),
    .CHANNEL_WIDTH(CW),
    .TX_DIR       (TD)
  ) dut (
    .clk_i              (clk_i),
    .srst_i             (srst_i),
    .dir_i              (dir_i),
    .ast_data_i         (ast_data_i),
    .ast_startofpacket_i(ast_startofpacket_i),
    .ast_endofpacket_i  (ast_endofpacket_i),
    .ast_valid_i        (ast_valid_i),
    .ast_empty_i        (ast_empty_i),
    .ast_channel_i      (ast_channel_i),
    .ast_ready_o        (ast_ready_o),
    .ast_data_o         (ast_data_o),
    .ast_startofpacket_o(ast_startofpacket_o),
    .ast_endofpacket_o  (ast_endofpacket_o),
    .ast_valid_o        (ast_valid_o),
    .ast_empty_o        (ast_empty_o),
    .ast_channel_o      (ast_channel_o),
    .ast_ready_i        (ast_ready_i)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic [SW-1:0] dir, input logic sop, input logic eop,
                       input logic [DW-1:0] data, input logic [EW-1:0] empty,
                       input logic [CW-1:0] ch);
    dir_i               = dir;
    ast_valid_i         = 1'b1;
    ast_startofpacket_i = sop;
    ast_endofpacket_i   = eop;
    ast_data_i          = data;
    ast_empty_i         = empty;
    ast_channel_i       = ch;
  endtask

  task automatic idle_in();
    ast_valid_i         = 1'b0;
    ast_startofpacket_i = 1'b0;
    ast_endofpacket_i   = 1'b0;
  endtask

  typedef struct packed {
    logic [DW-1:0] data;
    logic          sop;
    logic          eop;
    logic [EW-1:0] empty;
    logic [CW-1:0] ch;
  } beat_t;

  beat_t exp_q [TD][$];
  beat_t cur;
  beat_t e;
  bit    have_beat = 1'b0;
  int    pkt_len   = 0;
  int    beat_idx  = 0;
  int    pkt_dir   = 0;
  int    pkt_id    = 0;
  int    pkts_sent = 0;

  // Retire output handshakes happening at the coming edge, then record the accepted input beat.
  task automatic sb_sample();
    for (int d = 0; d < TD; d++) begin
      if (ast_valid_o[d] && ast_ready_i[d]) begin
        if (exp_q[d].size() == 0) begin
          check($sformatf("sb_extra_d%0d", d), 64'd1, 64'd0);
        end else begin
          e = exp_q[d].pop_front();
          check($sformatf("sb_data_d%0d", d), ast_data_o[d], e.data);
          check($sformatf("sb_ctl_d%0d", d),
                {ast_startofpacket_o[d], ast_endofpacket_o[d], ast_empty_o[d], ast_channel_o[d]},
                {e.sop, e.eop, e.empty, e.ch});
        end
      end
    end
    if (ast_valid_i && ast_ready_o && have_beat) begin
      exp_q[pkt_dir].push_back(cur);
      have_beat = 1'b0;
      beat_idx++;
      if (cur.eop) begin
        beat_idx = 0;
        pkt_id++;
        pkts_sent++;
      end
    end
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog expired got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    srst_i        = 1'b0;
    dir_i         = '0;
    ast_data_i    = '0;
    ast_empty_i   = '0;
    ast_channel_i = '0;
    ast_ready_i   = '0;
    idle_in();
    #1;
    check("rst_valid", ast_valid_o, 4'b0000);
    check("rst_ready", ast_ready_o, 1'b1);
    check("rst_data2", ast_data_o[2], 64'd0);
    check("rst_chan1", ast_channel_o[1], 8'd0);
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    srst_i = 1'b1;
    tick();

    // Three-beat packet to direction 2.
    ast_ready_i = 4'hF;
    drive(2'd2, 1'b1, 1'b0, 64'hA000_0000_0000_0000, 3'd0, 8'h5A);
    tick();
    check("p2_b0_valid", ast_valid_o, 4'b0100);
    check("p2_b0_data", ast_data_o[2], 64'hA000_0000_0000_0000);
    check("p2_b0_sop", ast_startofpacket_o[2], 1'b1);
    drive(2'd2, 1'b0, 1'b0, 64'hA000_0000_0000_0001, 3'd0, 8'h5A);
    tick();
    check("p2_b1_valid", ast_valid_o, 4'b0100);
    check("p2_b1_data", ast_data_o[2], 64'hA000_0000_0000_0001);
    drive(2'd2, 1'b0, 1'b1, 64'hA000_0000_0000_0002, 3'd3, 8'h5A);
    tick();
    check("p2_b2_valid", ast_valid_o, 4'b0100);
    check("p2_b2_data", ast_data_o[2], 64'hA000_0000_0000_0002);
    check("p2_b2_eop", ast_endofpacket_o[2], 1'b1);
    check("p2_b2_empty", ast_empty_o[2], 3'd3);
    check("p2_b2_chan", ast_channel_o[2], 8'h5A);
    idle_in();
    tick();
    check("p2_drained", ast_valid_o, 4'b0000);

    // dir_i changes after the start beat; the packet stays on direction 1.
    drive(2'd1, 1'b1, 1'b0, 64'hB0, 3'd0, 8'h11);
    tick();
    check("tog_b0", {ast_valid_o, ast_data_o[1]}, {4'b0010, 64'hB0});
    for (int i = 1; i < 4; i++) begin
      drive(2'd3, 1'b0, (i == 3), 64'hB0 + 64'(i), 3'd0, 8'h11);
      tick();
      check($sformatf("tog_b%0d", i), {ast_valid_o, ast_data_o[1]}, {4'b0010, 64'hB0 + 64'(i)});
    end
    drive(2'd3, 1'b1, 1'b1, 64'hB8, 3'd0, 8'h12);
    tick();
    check("tog_next_pkt", {ast_valid_o, ast_data_o[3]}, {4'b1000, 64'hB8});

    // Beat without SOP while idle follows dir_i.
    drive(2'd0, 1'b0, 1'b0, 64'hD0, 3'd0, 8'h00);
    tick();
    check("nosop_d0", {ast_valid_o, ast_data_o[0]}, {4'b0001, 64'hD0});
    drive(2'd3, 1'b0, 1'b1, 64'hD1, 3'd0, 8'h00);
    tick();
    check("nosop_d3", {ast_valid_o, ast_data_o[3]}, {4'b1000, 64'hD1});
    idle_in();
    tick();

    // Backpressure on direction 0.
    ast_ready_i = 4'b1110;
    drive(2'd0, 1'b1, 1'b1, 64'hC0, 3'd0, 8'h22);
    tick();
    check("bp_load", {ast_valid_o, ast_data_o[0]}, {4'b0001, 64'hC0});
    check("bp_ready_low", ast_ready_o, 1'b0);
    drive(2'd0, 1'b1, 1'b1, 64'hC1, 3'd0, 8'h22);
    tick();
    check("bp_hold", {ast_valid_o, ast_data_o[0]}, {4'b0001, 64'hC0});
    check("bp_still_low", ast_ready_o, 1'b0);
    idle_in();
    dir_i = 2'd1;
    #1;
    check("bp_other_dir", ast_ready_o, 1'b1);
    dir_i       = 2'd0;
    ast_ready_i = 4'hF;
    #1;
    check("bp_release", ast_ready_o, 1'b1);
    tick();
    check("bp_drained", ast_valid_o, 4'b0000);

    // Back-to-back single-beat packets to every direction.
    for (int i = 0; i < TD; i++) begin
      drive(SW'(i), 1'b1, 1'b1, 64'hE0 + 64'(i), 3'd0, 8'h33);
      tick();
      check($sformatf("b2b_d%0d", i), {ast_valid_o, ast_data_o[i]}, {4'(1 << i), 64'hE0 + 64'(i)});
    end
    idle_in();
    tick();

    // A new start beat mid-packet relocks the selection.
    drive(2'd1, 1'b1, 1'b0, 64'h90, 3'd0, 8'h44);
    tick();
    drive(2'd2, 1'b1, 1'b0, 64'h91, 3'd0, 8'h44);
    tick();
    drive(2'd0, 1'b0, 1'b1, 64'h92, 3'd0, 8'h44);
    tick();
    check("resop_reload", {ast_valid_o & 4'b0100, ast_data_o[2]}, {4'b0100, 64'h92});
    idle_in();
    tick();

    // Asynchronous reset in the middle of a packet.
    drive(2'd2, 1'b1, 1'b0, 64'hF0, 3'd0, 8'h55);
    tick();
    drive(2'd2, 1'b0, 1'b0, 64'hF1, 3'd0, 8'h55);
    tick();
    check("mid_rst_pre", ast_valid_o, 4'b0100);
    idle_in();
    #2;
    srst_i = 1'b0;
    #1;
    check("mid_rst_valid", ast_valid_o, 4'b0000);
    check("mid_rst_data", ast_data_o[2], 64'd0);
    @(negedge clk_i);
    srst_i = 1'b1;
    tick();
    drive(2'd1, 1'b1, 1'b1, 64'hF8, 3'd0, 8'h56);
    tick();
    check("post_rst_pkt", {ast_valid_o, ast_data_o[1]}, {4'b0010, 64'hF8});
    idle_in();
    tick();
    tick();

    // Randomized traffic against per-direction scoreboards.
    for (int cyc = 0; cyc < 30000 && pkts_sent < NPKT; cyc++) begin
      if (!have_beat) begin
        if (beat_idx == 0) begin
          pkt_len = $urandom_range(1, 16);
          pkt_dir = $urandom_range(0, TD - 1);
        end
        cur.sop   = (beat_idx == 0);
        cur.eop   = (beat_idx == pkt_len - 1);
        cur.data  = {$urandom, 16'(pkt_id), 16'(beat_idx)};
        cur.empty = cur.eop ? EW'($urandom) : '0;
        cur.ch    = CW'(pkt_id);
        have_beat = 1'b1;
      end
      ast_valid_i         = ($urandom_range(0, 3) != 0);
      dir_i               = (ast_valid_i && cur.sop) ? SW'(pkt_dir) : SW'($urandom);
      ast_startofpacket_i = cur.sop;
      ast_endofpacket_i   = cur.eop;
      ast_data_i          = cur.data;
      ast_empty_i         = cur.empty;
      ast_channel_i       = cur.ch;
      ast_ready_i         = TD'($urandom);
      @(negedge clk_i);
      sb_sample();
      tick();
    end
    check("rand_all_sent", pkts_sent, NPKT);
    idle_in();
    ast_ready_i = 4'hF;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i);
      sb_sample();
      tick();
    end
    for (int d = 0; d < TD; d++) begin
      check($sformatf("sb_left_d%0d", d), exp_q[d].size(), 0);
    end
    check("rand_final_valid", ast_valid_o, 4'b0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
